// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types and constants for the RO PUF challenge sequencer
package ro_puf_pkg;

  localparam int PAIR_W     = 8;
  localparam int SEL_W      = 4;
  localparam int MAJ_TRIALS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    RACE,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/puf_sync2.sv
// rtl/puf_sync2.sv - two-flop synchroniser for saturation flags from the RO domain
module puf_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ro_puf_challenge_ctrl.sv
// rtl/ro_puf_challenge_ctrl.sv - RO PUF challenge sequencer and response assembler
// Optional RO_PUF_MAJORITY_EN: three races per pair with a 2-of-3 vote.
module ro_puf_challenge_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_BITS        = 8,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_BITS*PAIR_W-1:0] challenge,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [N_BITS-1:0]        response,
  output logic                     tie_seen,
  output logic                     timeout_err,
  output logic [SEL_W-1:0]         cha0,
  output logic [SEL_W-1:0]         cha1,
  output logic                     cnt_clr_n,
  output logic                     ro_en,
  input  logic                     sat_a,
  input  logic                     sat_b
);

  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CW    = $clog2(CLR_CYCLES + SETTLE_CYCLES + 1);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t                     state;
  logic [N_BITS*PAIR_W-1:0]   chal;
  logic [IDX_W-1:0]           idx;
  logic [CW-1:0]              cnt;
  logic [TW-1:0]              timer;
  logic                       pair_bit;
  logic [PAIR_W-1:0]          pair;
  logic                       sa, sb;
  logic                       race_hit, win_b, tie_hit, to_hit;
`ifdef RO_PUF_MAJORITY_EN
  logic [1:0]                 trial;
  logic [1:0]                 votes;
`endif

  puf_sync2 u_sync_a (.clk(clk), .reset(reset), .d(sat_a), .q(sa));
  puf_sync2 u_sync_b (.clk(clk), .reset(reset), .d(sat_b), .q(sb));

  assign pair = chal[idx*PAIR_W +: PAIR_W];

  // A simultaneous saturation is a tie and reads as an A win.
  always_comb begin
    to_hit   = ~sa & ~sb & (timer == TW'(TIMEOUT));
    tie_hit  = sa & sb;
    win_b    = sb & ~sa;
    race_hit = sa | sb | to_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      chal        <= '0;
      idx         <= '0;
      cnt         <= '0;
      timer       <= '0;
      pair_bit    <= 1'b0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      response    <= '0;
      tie_seen    <= 1'b0;
      timeout_err <= 1'b0;
      cha0        <= '0;
      cha1        <= '0;
      cnt_clr_n   <= 1'b0;
      ro_en       <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
      trial       <= '0;
      votes       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt_clr_n <= 1'b0;
          ro_en     <= 1'b0;
          if (start) begin
            chal        <= challenge;
            idx         <= '0;
            response    <= '0;
            tie_seen    <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          cha0 <= pair[SEL_W-1:0];
          cha1 <= pair[PAIR_W-1:SEL_W];
          cnt  <= '0;
`ifdef RO_PUF_MAJORITY_EN
          trial <= '0;
          votes <= '0;
`endif
          if (pair[SEL_W-1:0] == pair[PAIR_W-1:SEL_W]) begin
            pair_bit <= 1'b0;
            tie_seen <= 1'b1;
            state    <= CAPTURE;
          end else begin
            state <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == CW'(CLR_CYCLES - 1)) begin
            cnt       <= '0;
            cnt_clr_n <= 1'b1;
            state     <= SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            timer <= '0;
            ro_en <= 1'b1;
            state <= RACE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RACE: begin
          if (race_hit) begin
            ro_en     <= 1'b0;
            cnt_clr_n <= 1'b0;
            if (tie_hit) tie_seen    <= 1'b1;
            if (to_hit)  timeout_err <= 1'b1;
`ifdef RO_PUF_MAJORITY_EN
            if (trial == 2'(MAJ_TRIALS - 1)) begin
              pair_bit <= ((votes + {1'b0, win_b}) >= 2'd2);
              state    <= CAPTURE;
            end else begin
              trial <= trial + 1'b1;
              votes <= votes + {1'b0, win_b};
              state <= CLEAR;
            end
`else
            pair_bit <= win_b;
            state    <= CAPTURE;
`endif
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CAPTURE: begin
          response[idx] <= pair_bit;
          ro_en         <= 1'b0;
          cnt_clr_n     <= 1'b0;
          if (idx == IDX_W'(N_BITS - 1)) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_challenge_ctrl.sv
// tb/tb_ro_puf_challenge_ctrl.sv - self-checking bench for ro_puf_challenge_ctrl
module tb_ro_puf_challenge_ctrl;

`ifdef RO_PUF_MAJORITY_EN
  localparam int NTR = 3;
`else
  localparam int NTR = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] challenge = '0;
  logic        busy, resp_valid, tie_seen, timeout_err, cnt_clr_n, ro_en;
  logic [1:0]  response;
  logic [3:0]  cha0, cha1;
  logic        sat_a = 1'b0;
  logic        sat_b = 1'b0;

  ro_puf_challenge_ctrl #(
    .N_BITS(2), .CLR_CYCLES(4), .SETTLE_CYCLES(2), .TIMEOUT(50)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .busy(busy), .resp_valid(resp_valid), .response(response),
    .tie_seen(tie_seen), .timeout_err(timeout_err),
    .cha0(cha0), .cha1(cha1), .cnt_clr_n(cnt_clr_n), .ro_en(ro_en),
    .sat_a(sat_a), .sat_b(sat_b)
  );

  always #5 clk = ~clk;

  // race outcome codes: 0 = A wins, 1 = B wins, 2 = tie, 3 = timeout
  typedef struct packed {
    logic [15:0] ch;
    logic [11:0] plan;
    logic [3:0]  exp;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         pda[6];
  int         pdb[6];
  int         plan_base = 0;
  int         race_cnt = 0;
  int         cyc_ro = 0;
  int         run = 0;
  int         clr_rel = 0;
  logic       prev_clr = 1'b0;
  int         obs_rd = 0;
  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];
  int         runs_q[$];
  logic [7:0] sel_q[$];
  vec_t       vecs[$];

  // counter-group model plus output monitor
  always @(negedge clk) begin
    int k;
    if (resp_valid) obs_q.push_back({response, tie_seen, timeout_err});
    if (!cnt_clr_n) begin
      sat_a = 1'b0;
      sat_b = 1'b0;
      cyc_ro = 0;
    end else if (ro_en) begin
      cyc_ro++;
      k = race_cnt - plan_base;
      if (k >= 0 && k < 6) begin
        if (cyc_ro == pda[k]) sat_a = 1'b1;
        if (cyc_ro == pdb[k]) sat_b = 1'b1;
      end
    end
    if (cnt_clr_n && !prev_clr) clr_rel++;
    prev_clr = cnt_clr_n;
    if (ro_en) begin
      if (run == 0) sel_q.push_back({cha1, cha0});
      run++;
    end else if (run > 0) begin
      runs_q.push_back(run);
      run = 0;
      race_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_plan(input logic [11:0] plan);
    plan_base = race_cnt;
    for (int r = 0; r < 6; r++) begin
      case (plan[2*r +: 2])
        2'd0:    begin pda[r] = 10;   pdb[r] = 110;  end
        2'd1:    begin pda[r] = 110;  pdb[r] = 10;   end
        2'd2:    begin pda[r] = 10;   pdb[r] = 10;   end
        default: begin pda[r] = 1000; pdb[r] = 1000; end
      endcase
    end
  endtask

  task automatic run_req(input logic [15:0] ch, input logic [11:0] plan,
                         input logic [3:0] exp, input string name, input bit dbl);
    int cyc;
    set_plan(plan);
    exp_q.push_back(exp);
    @(negedge clk);
    challenge = ch;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (dbl) begin
      repeat (10) @(negedge clk);
      challenge = 16'h3333;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (obs_q.size() <= obs_rd && cyc < 4000) begin
      @(posedge clk);
      cyc++;
    end
    if (obs_q.size() <= obs_rd) begin
      check({name, " resp_valid seen"}, 32'd0, 32'd1);
      exp_q.delete();
    end else begin
      check({name, " result"}, 32'(obs_q[obs_rd]), 32'(exp_q.pop_front()));
      obs_rd++;
    end
    repeat (dbl ? 300 : 3) @(negedge clk);
    check({name, " single resp_valid"}, 32'(obs_q.size() - obs_rd), 32'd0);
    check({name, " busy low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int sz, s0, cyc;
`ifdef RO_PUF_MAJORITY_EN
    vecs.push_back({16'h2110, 12'h611, 4'b0110});
    vecs.push_back({16'h2110, 12'h140, 4'b1000});
    vecs.push_back({16'h2110, 12'h417, 4'b0101});
`else
    vecs.push_back({16'h2110, 12'h000, 4'b0000});
    vecs.push_back({16'h2110, 12'h001, 4'b0100});
    vecs.push_back({16'h2110, 12'h006, 4'b1010});
    vecs.push_back({16'h5A2B, 12'h005, 4'b1100});
    vecs.push_back({16'h2110, 12'h007, 4'b1001});
`endif

    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, resp_valid, response, tie_seen, timeout_err,
                                cha0, cha1, cnt_clr_n, ro_en}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_req(vecs[i].ch, vecs[i].plan, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // timeout on every race: ro_en high TIMEOUT+1 cycles each, selects follow pairs
    sz = runs_q.size();
    s0 = sel_q.size();
    run_req(16'h2110, 12'hFFF, 4'b0001, "timeout", 1'b0);
    check("timeout race count", 32'(runs_q.size() - sz), 32'(2 * NTR));
    for (int r = sz; r < runs_q.size(); r++) check($sformatf("timeout ro_en len %0d", r - sz), 32'(runs_q[r]), 32'd51);
    for (int r = s0; r < sel_q.size(); r++)
      check($sformatf("select race %0d", r - s0), 32'(sel_q[r]), (r - s0 < NTR) ? 32'h10 : 32'h21);
    check("selects hold after done", 32'({cha1, cha0}), 32'h21);

    // equal-select pair 0 is never raced
    sz = runs_q.size();
    s0 = clr_rel;
    run_req(16'h2133, 12'h555, 4'b1010, "tie pair", 1'b0);
    check("tie pair race count", 32'(runs_q.size() - sz), 32'(NTR));
    check("tie pair clear releases", 32'(clr_rel - s0), 32'(NTR));
    if (sel_q.size() > 0) check("tie pair raced select", 32'(sel_q[sel_q.size() - 1]), 32'h21);

    // reset during RACE aborts without resp_valid
    set_plan(12'hFFF);
    exp_q.push_back(4'b0001);
    @(negedge clk);
    challenge = 16'h2110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!ro_en && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach race", 32'(ro_en), 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async reset outputs", 32'({busy, resp_valid, response, tie_seen, timeout_err,
                                      cha0, cha1, cnt_clr_n, ro_en}), 32'd0);
    exp_q.delete();
    repeat (100) @(negedge clk);
    check("no resp after abort", 32'(obs_q.size() - obs_rd), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_req(16'h2110, 12'h000, 4'b0000, "post reset + start while busy", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
